// File: rtl/weight_loader.sv
// Streams weights and a bias per neuron from a valid/ready source into neuron config strobes.
// Optional running checksum of accepted words when WEIGHT_LOADER_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// WEIGHT | accepting NUM_WEIGHTS weights for the current neuron
// BIAS   | accepting the bias word for the current neuron
// GAP    | one quiet cycle; advance neuron or finish
// FIN    | done pulse, back to IDLE
module weight_loader #(
  parameter int LAYER_NO    = 2,
  parameter int NUM_NEURONS = 30,
  parameter int NUM_WEIGHTS = 30,
  parameter int NEURON_BASE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weightValid,
  output logic [31:0] weightValue,
  output logic        biasValid,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int WCW = $clog2(NUM_WEIGHTS) + 1;
  localparam int NCW = $clog2(NUM_NEURONS) + 1;

  typedef enum logic [2:0] {IDLE, WEIGHT, BIAS, GAP, FIN} state_t;

  state_t         state, state_nx;
  logic [WCW-1:0] wcnt;
  logic [NCW-1:0] ncnt;
  logic           accept;
  logic           last_w;
  logic           last_n;

  assign accept = s_valid & s_ready;
  assign last_w = (wcnt == WCW'(NUM_WEIGHTS - 1));
  assign last_n = (ncnt == NCW'(NUM_NEURONS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = WEIGHT;
      WEIGHT: begin
        s_ready = 1'b1;
        if (s_valid && last_w) state_nx = BIAS;
      end
      BIAS:   begin
        s_ready = 1'b1;
        if (s_valid) state_nx = GAP;
      end
      GAP:    state_nx = last_n ? FIN : WEIGHT;
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status and config outputs decode the registered state so reset clears them at once.
  assign busy              = (state != IDLE);
  assign done              = (state == FIN);
  assign config_layer_num  = busy ? 32'(LAYER_NO) : 32'd0;
  assign config_neuron_num = busy ? (32'(NEURON_BASE) + 32'(ncnt)) : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt        <= '0;
      ncnt        <= '0;
      weightValid <= 1'b0;
      weightValue <= '0;
      biasValid   <= 1'b0;
      biasValue   <= '0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      if (state == IDLE && start) begin
        wcnt <= '0;
        ncnt <= '0;
      end
      if (accept && state == WEIGHT) begin
        weightValid <= 1'b1;
        weightValue <= s_data;
        wcnt        <= last_w ? '0 : wcnt + 1'b1;
      end
      if (accept && state == BIAS) begin
        biasValid <= 1'b1;
        biasValue <= s_data;
      end
      // Neuron index only moves after the bias strobe has been seen with the old index.
      if (state == GAP && !last_n) ncnt <= ncnt + 1'b1;
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (accept) checksum <= checksum + s_data;
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: directed runs on two instances (base/layer variants).
// Checksum checks are active when WEIGHT_LOADER_CHECKSUM_EN is defined.
module tb_weight_loader;

  typedef struct {
    int          kind;    // 0 weight, 1 bias, 2 done
    logic [31:0] val;     // word, or checksum for done
    logic [31:0] neuron;
    logic [31:0] layer;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start   [2];
  logic [31:0] s_data  [2];
  logic        s_valid [2];
  logic        s_ready [2];
  logic        wv      [2];
  logic [31:0] wval    [2];
  logic        bv      [2];
  logic [31:0] bval    [2];
  logic [31:0] lnum    [2];
  logic [31:0] nnum    [2];
  logic        busy    [2];
  logic        dn      [2];
  logic [31:0] cks     [2];

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        it0, it1;
  logic [31:0] words [8];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  weight_loader #(.LAYER_NO(2), .NUM_NEURONS(2), .NUM_WEIGHTS(3), .NEURON_BASE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .weightValid(wv[0]), .weightValue(wval[0]), .biasValid(bv[0]),
    .biasValue(bval[0]), .config_layer_num(lnum[0]), .config_neuron_num(nnum[0]),
    .busy(busy[0]), .done(dn[0])
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    , .checksum(cks[0])
`endif
  );

  weight_loader #(.LAYER_NO(3), .NUM_NEURONS(2), .NUM_WEIGHTS(3), .NEURON_BASE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .weightValid(wv[1]), .weightValue(wval[1]), .biasValid(bv[1]),
    .biasValue(bval[1]), .config_layer_num(lnum[1]), .config_neuron_num(nnum[1]),
    .busy(busy[1]), .done(dn[1])
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    , .checksum(cks[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input int base, input int layer);
    exp_t        it;
    logic [31:0] sum;
    sum = 32'd0;
    for (int n = 0; n < 2; n++) begin
      for (int j = 0; j < 4; j++) begin
        it.kind   = (j < 3) ? 0 : 1;
        it.val    = words[n*4+j];
        it.neuron = 32'(base + n);
        it.layer  = 32'(layer);
        sum       = sum + it.val;
        if (k == 0) q0.push_back(it); else q1.push_back(it);
      end
    end
    it.kind   = 2;
    it.val    = sum;
    it.neuron = 32'(base + 1);
    it.layer  = 32'(layer);
    if (k == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic check_evt(input int k, input exp_t it);
    int ka;
    ka = wv[k] ? 0 : (bv[k] ? 1 : 2);
    chk($sformatf("dut%0d_kind", k), 32'(ka), 32'(it.kind));
    if (ka == 0) chk($sformatf("dut%0d_weight", k), wval[k], it.val);
    if (ka == 1) chk($sformatf("dut%0d_bias", k), bval[k], it.val);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    if (ka == 2) chk($sformatf("dut%0d_checksum", k), cks[k], it.val);
`endif
    chk($sformatf("dut%0d_neuron", k), nnum[k], it.neuron);
    chk($sformatf("dut%0d_layer", k), lnum[k], it.layer);
  endtask

  task automatic unexpected(input int k);
    n_checks++;
    n_fail++;
    $display("FAIL dut%0d_unexpected_event: got wv=%0b bv=%0b done=%0b expected no event", k, wv[k], bv[k], dn[k]);
  endtask

  always @(negedge clk) begin
    if (wv[0] || bv[0]) chk("dut0_strobe_exclusive", 32'(wv[0] & bv[0]), 32'd0);
    if (wv[0] || bv[0] || dn[0]) begin
      if (q0.size() == 0) unexpected(0);
      else begin it0 = q0.pop_front(); check_evt(0, it0); end
    end
    if (wv[1] || bv[1]) chk("dut1_strobe_exclusive", 32'(wv[1] & bv[1]), 32'd0);
    if (wv[1] || bv[1] || dn[1]) begin
      if (q1.size() == 0) unexpected(1);
      else begin it1 = q1.pop_front(); check_evt(1, it1); end
    end
  end

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk($sformatf("dut%0d_busy_after_start", k), 32'(busy[k]), 32'd1);
  endtask

  task automatic send_word(input int k, input logic [31:0] w, input bit bubble, input bit with_start);
    int t;
    s_valid[k] = 1'b1;
    s_data[k]  = w;
    start[k]   = with_start;
    t = 0;
    @(negedge clk);
    while (!s_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk($sformatf("dut%0d_ready_timeout", k), 32'(s_ready[k]), 32'd1);
    @(posedge clk); #1;
    s_valid[k] = 1'b0;
    start[k]   = 1'b0;
    if (bubble) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (((k == 0 ? q0.size() : q1.size()) != 0 || busy[k]) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("dut%0d_drain_queue", k), 32'(k == 0 ? q0.size() : q1.size()), 32'd0);
    chk($sformatf("dut%0d_drain_busy", k), 32'(busy[k]), 32'd0);
  endtask

  task automatic run(input int k, input int base, input int layer, input bit bubble, input int start_at);
    push_exp(k, base, layer);
    pulse_start(k);
    for (int i = 0; i < 8; i++) send_word(k, words[i], bubble, (i == start_at));
    drain(k);
  endtask

  task automatic check_idle(input int k, input string tag);
    chk($sformatf("%s_s_ready", tag), 32'(s_ready[k]), 32'd0);
    chk($sformatf("%s_weightValid", tag), 32'(wv[k]), 32'd0);
    chk($sformatf("%s_weightValue", tag), wval[k], 32'd0);
    chk($sformatf("%s_biasValid", tag), 32'(bv[k]), 32'd0);
    chk($sformatf("%s_biasValue", tag), bval[k], 32'd0);
    chk($sformatf("%s_layer", tag), lnum[k], 32'd0);
    chk($sformatf("%s_neuron", tag), nnum[k], 32'd0);
    chk($sformatf("%s_busy", tag), 32'(busy[k]), 32'd0);
    chk($sformatf("%s_done", tag), 32'(dn[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; s_valid[k] = 1'b0; s_data[k] = 32'd0;
    end
    for (int i = 0; i < 8; i++) words[i] = 32'(i + 1);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle(0, "reset");
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk("reset_checksum", cks[0], 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b1;

    // basic load, s_valid held high
    run(0, 0, 2, 1'b0, -1);
    // bubbly source
    run(0, 0, 2, 1'b1, -1);
    // start while busy is ignored
    for (int i = 0; i < 8; i++) words[i] = 32'(i + 10);
    run(0, 0, 2, 1'b0, 1);

    // reset after the 2nd weight, then a clean reload
    for (int i = 0; i < 8; i++) words[i] = 32'(i + 1);
    push_exp(0, 0, 2);
    pulse_start(0);
    send_word(0, words[0], 1'b0, 1'b0);
    send_word(0, words[1], 1'b0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_idle(0, "midrun_reset");
    q0.delete();
    @(posedge clk); #1 rst = 1'b1;
    run(0, 0, 2, 1'b0, -1);

    // neuron base and layer offset
    run(1, 1, 3, 1'b0, -1);

    // checksum wrap
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'd2;
    for (int i = 2; i < 8; i++) words[i] = 32'd0;
    run(0, 0, 2, 1'b1, -1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
